// File: rtl/vga_bar_update_sched_if.sv
//------------------------------------------------------------------------------
// Module : vga_bar_update_sched_if
// Brief  : Producer/display bus for the frame-synchronous bar update scheduler.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

interface vga_bar_update_sched_if #(
    parameter int NBARS = 6,
    parameter int DW    = 11
) ();
    logic [9:0]          hc_in;
    logic [9:0]          vc_in;
    logic [NBARS-1:0]    req;
    logic [NBARS*DW-1:0] req_data;
    logic [NBARS-1:0]    gnt;
    logic [NBARS*DW-1:0] sum_out;
    logic [NBARS-1:0]    bar_hit;
    logic                frame_swap;
    logic [NBARS-1:0]    overrun;

    modport master (
        output hc_in, vc_in, req, req_data,
        input  gnt, sum_out, bar_hit, frame_swap, overrun
    );

    modport slave (
        input  hc_in, vc_in, req, req_data,
        output gnt, sum_out, bar_hit, frame_swap, overrun
    );
endinterface

`default_nettype wire

// File: rtl/vga_bar_update_sched.sv
//------------------------------------------------------------------------------
// Module : vga_bar_update_sched
// Brief  : Round-robin shadow-bank writer with tear-free display-bank swap at VFP.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module vga_bar_update_sched #(
    parameter int NBARS   = 6,
    parameter int DW      = 11,
    parameter int THRESH  = 675,
    parameter int HPIXELS = 800,
    parameter int VLINES  = 521,
    parameter int VFP     = 511
) (
    input  wire logic               dclk,
    input  wire logic               clr_n,
    vga_bar_update_sched_if.slave   bus
);

    localparam int              c_PW             = (NBARS > 1) ? $clog2(NBARS) : 1;
    localparam logic [9:0]      c_VFP            = 10'(VFP);
    localparam logic [DW-1:0]   c_THRESH         = DW'(THRESH);
    localparam bit              c_SWAP_REACHABLE = (VFP < VLINES) && (HPIXELS > 0);

    typedef enum logic [0:0] {
        S_ACCEPT = 1'b0,
        S_SWAP   = 1'b1
    } state_t;

    state_t              r_state;
    logic [c_PW-1:0]     r_ptr;
    logic [DW-1:0]       r_shadow [NBARS];
    logic [NBARS-1:0]    r_dirty;
    logic [NBARS-1:0]    r_overrun;
    logic [NBARS-1:0]    r_bar_hit;
    logic [NBARS*DW-1:0] r_sum_out;
    logic                r_frame_swap;

    logic                w_swap_evt;
    logic                w_pick_vld;
    logic [c_PW-1:0]     w_pick_idx;
    logic [c_PW-1:0]     w_next_ptr;
    logic [NBARS-1:0]    w_pick;
    logic [NBARS-1:0]    w_gnt;
    logic [DW-1:0]       w_req_val [NBARS];
    logic [DW-1:0]       w_wr_val;

    // Index base+off folded back into 0..NBARS-1 (off never exceeds NBARS-1).
    function automatic logic [c_PW-1:0] f_wrap(input logic [c_PW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NBARS) s = s - NBARS;
        return c_PW'(s);
    endfunction

    assign w_swap_evt = c_SWAP_REACHABLE && (bus.vc_in == c_VFP) && (bus.hc_in == 10'd0);

    always_comb begin
        w_pick_vld = 1'b0;
        w_pick_idx = '0;
        for (int k = 0; k < NBARS; k++) begin
            if (!w_pick_vld && bus.req[f_wrap(r_ptr, k)]) begin
                w_pick_vld = 1'b1;
                w_pick_idx = f_wrap(r_ptr, k);
            end
        end
        for (int i = 0; i < NBARS; i++) begin
            w_pick[i]    = w_pick_vld && (w_pick_idx == c_PW'(i));
            w_req_val[i] = bus.req_data[i*DW +: DW];
        end
        w_next_ptr = f_wrap(w_pick_idx, 1);
        w_wr_val   = w_req_val[w_pick_idx];
    end

    // Grant is combinational so a producer is served in the cycle it asks.
    assign w_gnt = (clr_n && (r_state == S_ACCEPT)) ? w_pick : '0;

    always_ff @(posedge dclk or negedge clr_n) begin
        if (!clr_n) begin
            r_state      <= S_ACCEPT;
            r_ptr        <= '0;
            r_dirty      <= '0;
            r_overrun    <= '0;
            r_bar_hit    <= '0;
            r_sum_out    <= '0;
            r_frame_swap <= 1'b0;
            for (int i = 0; i < NBARS; i++) begin
                r_shadow[i] <= '0;
            end
        end else begin
            r_frame_swap <= 1'b0;
            case (r_state)
                S_ACCEPT: begin
                    if (w_pick_vld) begin
                        r_shadow[w_pick_idx] <= w_wr_val;
                        r_dirty[w_pick_idx]  <= 1'b1;
                        if (r_dirty[w_pick_idx]) begin
                            r_overrun[w_pick_idx] <= 1'b1;
                        end
                        r_ptr <= w_next_ptr;
                    end
                    if (w_swap_evt) begin
                        r_state <= S_SWAP;
                    end
                end
                S_SWAP: begin
                    for (int i = 0; i < NBARS; i++) begin
                        r_sum_out[i*DW +: DW] <= r_shadow[i];
                        r_bar_hit[i]          <= (r_shadow[i] > c_THRESH);
                    end
                    r_frame_swap <= 1'b1;
                    r_dirty      <= '0;
                    r_overrun    <= '0;
                    r_state      <= S_ACCEPT;
                end
                default: r_state <= S_ACCEPT;
            endcase
        end
    end

    assign bus.gnt        = w_gnt;
    assign bus.sum_out    = r_sum_out;
    assign bus.bar_hit    = r_bar_hit;
    assign bus.frame_swap = r_frame_swap;
    assign bus.overrun    = r_overrun;

endmodule

`default_nettype wire

// File: tb/tb_vga_bar_update_sched.sv
//------------------------------------------------------------------------------
// Module : tb_vga_bar_update_sched
// Brief  : Self-checking bench for vga_bar_update_sched.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_vga_bar_update_sched;

    localparam int NBARS = 6;
    localparam int DW    = 11;
    localparam int THR   = 675;

    logic dclk  = 1'b0;
    logic clr_n = 1'b1;

    vga_bar_update_sched_if #(.NBARS(NBARS), .DW(DW)) bus ();

    vga_bar_update_sched #(
        .NBARS(NBARS), .DW(DW), .THRESH(THR),
        .HPIXELS(800), .VLINES(521), .VFP(511)
    ) dut (
        .dclk  (dclk),
        .clr_n (clr_n),
        .bus   (bus)
    );

    always #5 dclk = ~dclk;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [NBARS-1:0] req;
        logic [NBARS-1:0] exp_gnt;
    } vec_t;

    vec_t tbl [9];

    // Reference model state: bar values as seen by producers and by the display.
    int m_shadow [NBARS];
    int m_disp   [NBARS];
    bit m_dirty  [NBARS];
    bit m_ovr    [NBARS];
    int m_ptr;
    bit m_swap;
    bit m_fs;
    bit p_pend   [NBARS];
    int p_val    [NBARS];

    task automatic cmp(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual %h required %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge dclk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic do_reset();
        bus.req      = '0;
        bus.req_data = '0;
        bus.hc_in    = 10'd7;
        bus.vc_in    = 10'd100;
        clr_n        = 1'b0;
        tick();
        tick();
        clr_n = 1'b1;
    endtask

    task automatic produce(input int i, input int v);
        bit ok;
        ok = 1'b0;
        bus.req_data[i*DW +: DW] = DW'(v);
        bus.req[i] = 1'b1;
        for (int c = 0; c < 20 && !ok; c++) begin
            settle();
            if (bus.gnt[i]) ok = 1'b1;
            tick();
        end
        bus.req[i] = 1'b0;
        cmp("grant_wait", 128'(ok), 128'(1));
    endtask

    // Swap event for one cycle, then the SWAP cycle; returns in the frame_swap cycle.
    task automatic do_swap();
        bus.vc_in = 10'd511;
        bus.hc_in = 10'd0;
        tick();
        bus.vc_in = 10'd100;
        bus.hc_in = 10'd7;
        tick();
    endtask

    function automatic logic [NBARS*DW-1:0] bar(input int i, input int v);
        logic [NBARS*DW-1:0] r;
        r = '0;
        r[i*DW +: DW] = DW'(v);
        return r;
    endfunction

    initial begin
        logic [NBARS*DW-1:0] e_sum;
        logic [NBARS-1:0]    e_gnt;
        logic [NBARS-1:0]    e_hit;
        logic [NBARS-1:0]    e_ovr;
        bit                  evt;
        int                  idx;

        bus.req      = '0;
        bus.req_data = '0;
        bus.hc_in    = 10'd7;
        bus.vc_in    = 10'd100;

        // Reset with every producer requesting
        #1 clr_n = 1'b0;
        tick();
        tick();
        bus.req = 6'h3F;
        settle();
        cmp("rst_gnt",        128'(bus.gnt),        128'(0));
        cmp("rst_sum",        128'(bus.sum_out),    128'(0));
        cmp("rst_hit",        128'(bus.bar_hit),    128'(0));
        cmp("rst_overrun",    128'(bus.overrun),    128'(0));
        cmp("rst_frame_swap", 128'(bus.frame_swap), 128'(0));

        // Round-robin table, pointer starts at 0
        tbl[0] = '{6'b100101, 6'b000001};
        tbl[1] = '{6'b100101, 6'b000100};
        tbl[2] = '{6'b100101, 6'b100000};
        tbl[3] = '{6'b100101, 6'b000001};
        tbl[4] = '{6'b000000, 6'b000000};
        tbl[5] = '{6'b000001, 6'b000001};
        tbl[6] = '{6'b111111, 6'b000010};
        tbl[7] = '{6'b010000, 6'b010000};
        tbl[8] = '{6'b001000, 6'b001000};
        do_reset();
        for (int i = 0; i < 9; i++) begin
            bus.req = tbl[i].req;
            settle();
            cmp($sformatf("rr_gnt[%0d]", i), 128'(bus.gnt), 128'(tbl[i].exp_gnt));
            tick();
        end
        bus.req = '0;

        // Frame sync: writes invisible until the swap completes
        do_reset();
        produce(0, 700);
        produce(1, 600);
        tick();
        tick();
        settle();
        cmp("no_tear_sum", 128'(bus.sum_out), 128'(0));
        bus.vc_in = 10'd511;
        bus.hc_in = 10'd0;
        settle();
        cmp("evt_cycle_sum", 128'(bus.sum_out), 128'(0));
        tick();
        bus.vc_in = 10'd100;
        bus.hc_in = 10'd7;
        bus.req[5] = 1'b1;
        settle();
        cmp("swap_gnt_zero", 128'(bus.gnt),        128'(0));
        cmp("swap_sum_hold", 128'(bus.sum_out),    128'(0));
        cmp("swap_fs_low",   128'(bus.frame_swap), 128'(0));
        tick();
        settle();
        e_sum = bar(0, 700) | bar(1, 600);
        cmp("fs_sum",     128'(bus.sum_out),    128'(e_sum));
        cmp("fs_hit",     128'(bus.bar_hit),    128'(6'b000001));
        cmp("fs_pulse",   128'(bus.frame_swap), 128'(1));
        cmp("stall_resume_gnt", 128'(bus.gnt),  128'(6'b100000));
        tick();
        bus.req[5] = 1'b0;
        settle();
        cmp("fs_pulse_end", 128'(bus.frame_swap), 128'(0));

        // Threshold edge: equal is not a hit, one above is; bar0 persists
        produce(2, 675);
        do_swap();
        settle();
        cmp("thr_eq_hit",  128'(bus.bar_hit), 128'(6'b000001));
        cmp("thr_eq_val",  128'(bus.sum_out[2*DW +: DW]), 128'(675));
        produce(2, 676);
        do_swap();
        settle();
        cmp("thr_gt_hit",  128'(bus.bar_hit), 128'(6'b000101));
        cmp("persist_b0",  128'(bus.sum_out[0 +: DW]), 128'(700));

        // Overrun: two writes in one frame, last wins, flag clears at swap
        produce(3, 10);
        settle();
        cmp("ovr_single", 128'(bus.overrun), 128'(0));
        produce(3, 20);
        settle();
        cmp("ovr_set", 128'(bus.overrun), 128'(6'b001000));
        do_swap();
        settle();
        cmp("ovr_last_wins", 128'(bus.sum_out[3*DW +: DW]), 128'(20));
        cmp("ovr_cleared",   128'(bus.overrun),             128'(0));
        cmp("ovr_fs",        128'(bus.frame_swap),          128'(1));

        // Collision: request arrives on the swap-event cycle
        tick();
        bus.req_data[4*DW +: DW] = DW'(123);
        bus.req[4] = 1'b1;
        bus.vc_in  = 10'd511;
        bus.hc_in  = 10'd0;
        settle();
        cmp("coll_gnt", 128'(bus.gnt), 128'(6'b010000));
        tick();
        bus.req[4] = 1'b0;
        bus.req[0] = 1'b1;
        bus.vc_in  = 10'd100;
        bus.hc_in  = 10'd7;
        settle();
        cmp("coll_swap_gnt", 128'(bus.gnt), 128'(0));
        bus.req[0] = 1'b0;
        tick();
        settle();
        cmp("coll_included", 128'(bus.sum_out[4*DW +: DW]), 128'(123));
        cmp("coll_fs",       128'(bus.frame_swap),          128'(1));

        // Asynchronous reset in the middle of the SWAP cycle
        tick();
        produce(5, 999);
        bus.vc_in = 10'd511;
        bus.hc_in = 10'd0;
        tick();
        bus.vc_in = 10'd100;
        bus.hc_in = 10'd7;
        clr_n = 1'b0;
        settle();
        cmp("rst_swap_sum", 128'(bus.sum_out), 128'(0));
        cmp("rst_swap_hit", 128'(bus.bar_hit), 128'(0));
        tick();
        clr_n = 1'b1;
        settle();
        cmp("rst_swap_no_fs",  128'(bus.frame_swap), 128'(0));
        cmp("rst_swap_sum2",   128'(bus.sum_out),    128'(0));
        tick();
        settle();
        cmp("rst_swap_no_fs2", 128'(bus.frame_swap), 128'(0));

        // Randomized producers and timing against the reference model
        do_reset();
        for (int i = 0; i < NBARS; i++) begin
            m_shadow[i] = 0;
            m_disp[i]   = 0;
            m_dirty[i]  = 1'b0;
            m_ovr[i]    = 1'b0;
            p_pend[i]   = 1'b0;
            p_val[i]    = 0;
        end
        m_ptr  = 0;
        m_swap = 1'b0;
        m_fs   = 1'b0;

        for (int cyc = 1; cyc <= 4000; cyc++) begin
            for (int i = 0; i < NBARS; i++) begin
                if (!p_pend[i] && $urandom_range(0, 3) == 0) begin
                    p_pend[i] = 1'b1;
                    case ($urandom_range(0, 3))
                        0:       p_val[i] = THR - 1;
                        1:       p_val[i] = THR;
                        2:       p_val[i] = THR + 1;
                        default: p_val[i] = int'($urandom_range(0, 2047));
                    endcase
                end
                bus.req[i] = p_pend[i];
                bus.req_data[i*DW +: DW] = DW'(p_val[i]);
            end
            if (cyc % 37 == 0 || cyc % 111 == 1) begin
                bus.vc_in = 10'd511;
                bus.hc_in = 10'd0;
            end else if ($urandom_range(0, 9) == 0) begin
                bus.vc_in = 10'd511;
                bus.hc_in = 10'($urandom_range(1, 1023));
            end else begin
                bus.vc_in = 10'($urandom_range(0, 1023));
                bus.hc_in = 10'($urandom_range(1, 1023));
            end
            settle();

            e_gnt = '0;
            idx   = -1;
            if (!m_swap) begin
                for (int k = 0; k < NBARS; k++) begin
                    if (idx < 0 && bus.req[(m_ptr + k) % NBARS]) idx = (m_ptr + k) % NBARS;
                end
                if (idx >= 0) e_gnt[idx] = 1'b1;
            end
            e_sum = '0;
            for (int i = 0; i < NBARS; i++) begin
                e_sum[i*DW +: DW] = DW'(m_disp[i]);
                e_hit[i] = (m_disp[i] > THR);
                e_ovr[i] = m_ovr[i];
            end
            cmp("rnd_gnt", 128'(bus.gnt),        128'(e_gnt));
            cmp("rnd_sum", 128'(bus.sum_out),    128'(e_sum));
            cmp("rnd_hit", 128'(bus.bar_hit),    128'(e_hit));
            cmp("rnd_ovr", 128'(bus.overrun),    128'(e_ovr));
            cmp("rnd_fs",  128'(bus.frame_swap), 128'(m_fs));

            evt = (bus.vc_in == 10'd511) && (bus.hc_in == 10'd0);
            if (m_swap) begin
                for (int i = 0; i < NBARS; i++) begin
                    m_disp[i]  = m_shadow[i];
                    m_dirty[i] = 1'b0;
                    m_ovr[i]   = 1'b0;
                end
                m_fs   = 1'b1;
                m_swap = 1'b0;
            end else begin
                m_fs = 1'b0;
                if (idx >= 0) begin
                    if (m_dirty[idx]) m_ovr[idx] = 1'b1;
                    m_shadow[idx] = p_val[idx];
                    m_dirty[idx]  = 1'b1;
                    m_ptr         = (idx + 1) % NBARS;
                    p_pend[idx]   = 1'b0;
                end
                if (evt) m_swap = 1'b1;
            end
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1);
    end

endmodule

`default_nettype wire
